hazard_forward_unit: RTL and testbench

Backward-path companion to the forward control pipeline. Tracks the destination register, RegWrite and MemRead of every instruction in flight in EX, MEM and WB, and drives the values that flow back to decode:
- Da/Db forwarding selects.
- A load-use stall.
- A bubble into ID/EX.
- A saturating stall counter for performance monitoring.

---
 rtl/hazard_forward_unit.sv | 104 ++++++++++
 tb/tb_hazard_forward_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit: tracks EX/MEM/WB destinations and drives
// forwarding selects, load-use stall, ID/EX bubble and a stall counter.
module hazard_forward_unit #(
  parameter int REGBITS = 5,
  parameter int ZEROREG = 31,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_id,
  input  logic [REGBITS-1:0] Rn_id,
  input  logic [REGBITS-1:0] Rm_id,
  input  logic               useRn_id,
  input  logic               useRm_id,
  input  logic [REGBITS-1:0] Rd_id,
  input  logic               RegWrite_id,
  input  logic               MemRead_id,
  input  logic               flush,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic               stall,
  output logic               bubble,
  output logic [CNTW-1:0]    stall_count
);

  typedef struct packed {
    logic               v;
    logic [REGBITS-1:0] rd;
    logic               rw;
    logic               mr;
  } slot_t;

  localparam logic [REGBITS-1:0] ZR = REGBITS'(ZEROREG);

  slot_t ex_q, mem_q, wb_q, ex_d;

  logic rn_ok, rm_ok;
  logic hxa, hma, hwa;
  logic hxb, hmb, hwb;
  logic loaduse;

  function automatic logic hit(
    input slot_t s,
    input logic [REGBITS-1:0] r
  );
    return s.v & s.rw & (s.rd == r) & (r != ZR);
  endfunction

  always_comb begin
    rn_ok = valid_id & useRn_id;
    rm_ok = valid_id & useRm_id;
    hxa = rn_ok & hit(ex_q, Rn_id);
    hma = rn_ok & hit(mem_q, Rn_id);
    hwa = rn_ok & hit(wb_q, Rn_id);
    hxb = rm_ok & hit(ex_q, Rm_id);
    hmb = rm_ok & hit(mem_q, Rm_id);
    hwb = rm_ok & hit(wb_q, Rm_id);
  end

  // youngest producer wins
  always_comb begin
    ForwardA = 2'b00;
    if (hxa)      ForwardA = 2'b01;
    else if (hma) ForwardA = 2'b10;
    else if (hwa) ForwardA = 2'b11;
    ForwardB = 2'b00;
    if (hxb)      ForwardB = 2'b01;
    else if (hmb) ForwardB = 2'b10;
    else if (hwb) ForwardB = 2'b11;
  end

  always_comb begin
    loaduse = ex_q.mr & (hxa | hxb);
    stall   = loaduse & ~flush;
    bubble  = stall | flush;
    ex_d    = '0;
    if (!bubble) begin
      ex_d = '{v: valid_id, rd: Rd_id,
               rw: RegWrite_id, mr: MemRead_id};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // saturates instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != '1) begin
      stall_count <= stall_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: per-step expectations are
// queued with the stimulus and popped when the outputs settle.
module tb_hazard_forward_unit;

  // narrow counter so saturation is reached in a few thousand cycles
  localparam int CNTW = 10;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid_id = 1'b0;
  logic [4:0]      Rn_id = '0;
  logic [4:0]      Rm_id = '0;
  logic            useRn_id = 1'b0;
  logic            useRm_id = 1'b0;
  logic [4:0]      Rd_id = '0;
  logic            RegWrite_id = 1'b0;
  logic            MemRead_id = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      ForwardA, ForwardB;
  logic            stall, bubble;
  logic [CNTW-1:0] stall_count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
  } in_t;

  typedef struct packed {
    logic            chk;
    logic [1:0]      fa;
    logic [1:0]      fb;
    logic            st;
    logic            bb;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  hazard_forward_unit #(
    .REGBITS(5), .ZEROREG(31), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id),
    .Rn_id(Rn_id), .Rm_id(Rm_id),
    .useRn_id(useRn_id), .useRm_id(useRm_id),
    .Rd_id(Rd_id), .RegWrite_id(RegWrite_id),
    .MemRead_id(MemRead_id), .flush(flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .stall(stall), .bubble(bubble),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic in_t I(int v, int rn, int rm, int urn,
                            int urm, int rd, int rw, int mr, int fl);
    in_t s;
    s.v = 1'(v); s.rn = 5'(rn); s.rm = 5'(rm);
    s.urn = 1'(urn); s.urm = 1'(urm); s.rd = 5'(rd);
    s.rw = 1'(rw); s.mr = 1'(mr); s.fl = 1'(fl);
    return s;
  endfunction

  function automatic exp_t E(int chk, int fa, int fb, int st,
                             int bb, int cnt);
    exp_t e;
    e.chk = 1'(chk); e.fa = 2'(fa); e.fb = 2'(fb);
    e.st = 1'(st); e.bb = 1'(bb); e.cnt = CNTW'(cnt);
    return e;
  endfunction

  task automatic drive(input in_t s);
    valid_id = s.v; Rn_id = s.rn; Rm_id = s.rm;
    useRn_id = s.urn; useRm_id = s.urm; Rd_id = s.rd;
    RegWrite_id = s.rw; MemRead_id = s.mr; flush = s.fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [CNTW+5:0] o, w;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(I(1, 4, 4, 1, 1, 4, 1, 1, i));
      exp_q.push_back(E(1, 0, 0, 0, i, 0));
      #1;
      e = exp_q.pop_front();
      o = {ForwardA, ForwardB, stall, bubble, stall_count};
      w = {e.fa, e.fb, e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL reset[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_forward_ex_mem_wb();
    in_t s[5];
    exp_t x[5];
    exp_t e;
    logic [CNTW+5:0] o, w;
    s[0] = I(1, 9, 10, 1, 1, 1, 1, 0, 0);  x[0] = E(1, 0, 0, 0, 0, 0);
    s[1] = I(1, 1, 10, 1, 1, 11, 1, 0, 0); x[1] = E(1, 1, 0, 0, 0, 0);
    s[2] = I(1, 1, 13, 1, 1, 12, 1, 0, 0); x[2] = E(1, 2, 0, 0, 0, 0);
    s[3] = I(1, 1, 14, 1, 1, 15, 1, 0, 0); x[3] = E(1, 3, 0, 0, 0, 0);
    s[4] = I(1, 1, 11, 1, 1, 16, 1, 0, 0); x[4] = E(1, 0, 3, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(x[i]);
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL fwd[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    in_t s[5];
    exp_t x[5];
    exp_t e;
    logic [CNTW+5:0] o, w;
    s[0] = I(1, 20, 21, 1, 1, 2, 1, 1, 0); x[0] = E(1, 0, 0, 0, 0, 0);
    s[1] = I(1, 21, 2, 1, 1, 22, 1, 0, 0); x[1] = E(0, 0, 0, 1, 1, 0);
    s[2] = s[1];                           x[2] = E(1, 0, 2, 0, 0, 1);
    s[3] = I(0, 0, 0, 0, 0, 0, 0, 0, 0);   x[3] = E(1, 0, 0, 0, 0, 1);
    s[4] = I(1, 22, 2, 1, 1, 0, 0, 0, 0);  x[4] = E(1, 2, 0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(x[i]);
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL loaduse[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  task automatic test_priority();
    in_t s[6];
    exp_t x[6];
    exp_t e;
    logic [CNTW+5:0] o, w;
    s[0] = I(1, 0, 0, 0, 0, 3, 1, 0, 0);  x[0] = E(1, 0, 0, 0, 0, 0);
    s[1] = s[0];                          x[1] = E(1, 0, 0, 0, 0, 0);
    s[2] = s[0];                          x[2] = E(1, 0, 0, 0, 0, 0);
    s[3] = I(1, 3, 3, 1, 1, 4, 1, 0, 0);  x[3] = E(1, 1, 1, 0, 0, 0);
    s[4] = s[3];                          x[4] = E(1, 2, 2, 0, 0, 0);
    s[5] = s[3];                          x[5] = E(1, 3, 3, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(x[i]);
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL prio[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  task automatic test_no_match();
    in_t s[7];
    exp_t x[7];
    exp_t e;
    logic [CNTW+5:0] o, w;
    s[0] = I(1, 0, 0, 0, 0, 31, 1, 1, 0); x[0] = E(1, 0, 0, 0, 0, 0);
    s[1] = I(1, 31, 31, 1, 1, 7, 1, 0, 0); x[1] = E(1, 0, 0, 0, 0, 0);
    s[2] = I(1, 0, 0, 0, 0, 5, 0, 0, 0);  x[2] = E(1, 0, 0, 0, 0, 0);
    s[3] = I(1, 5, 5, 1, 1, 8, 1, 0, 0);  x[3] = E(1, 0, 0, 0, 0, 0);
    s[4] = I(1, 0, 0, 0, 0, 6, 1, 1, 0);  x[4] = E(1, 0, 0, 0, 0, 0);
    s[5] = I(1, 6, 6, 0, 0, 9, 1, 0, 0);  x[5] = E(1, 0, 0, 0, 0, 0);
    s[6] = I(0, 9, 9, 1, 1, 0, 0, 0, 0);  x[6] = E(1, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(x[i]);
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL nomatch[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  task automatic test_flush();
    in_t s[4];
    exp_t x[4];
    exp_t e;
    logic [CNTW+5:0] o, w;
    s[0] = I(1, 20, 21, 1, 1, 2, 1, 1, 0); x[0] = E(1, 0, 0, 0, 0, 0);
    s[1] = I(1, 21, 2, 1, 1, 8, 1, 0, 1);  x[1] = E(1, 0, 1, 0, 1, 0);
    s[2] = I(0, 0, 0, 0, 0, 0, 0, 0, 0);   x[2] = E(1, 0, 0, 0, 0, 0);
    s[3] = I(1, 8, 2, 1, 1, 0, 0, 0, 0);   x[3] = E(1, 0, 3, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(x[i]);
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL flush[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  // steps 4 and 5 assert reset mid-stall, then release it
  task automatic test_reset_mid_stall();
    in_t s[6];
    exp_t x[6];
    exp_t e;
    logic [CNTW+5:0] o, w;
    s[0] = I(1, 0, 0, 0, 0, 2, 1, 1, 0); x[0] = E(1, 0, 0, 0, 0, 0);
    s[1] = I(1, 2, 0, 1, 0, 2, 1, 1, 0); x[1] = E(0, 0, 0, 1, 1, 0);
    s[2] = s[1];                         x[2] = E(1, 2, 0, 0, 0, 1);
    s[3] = s[1];                         x[3] = E(0, 0, 0, 1, 1, 1);
    s[4] = s[1];                         x[4] = E(1, 0, 0, 0, 0, 0);
    s[5] = s[1];                         x[5] = E(1, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        reset = 1'b1;
      end else begin
        @(negedge clk);
        reset = 1'b0;
      end
      drive(s[i]);
      exp_q.push_back(x[i]);
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL midrst[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 i, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  // self-dependent load: stalls every other cycle
  task automatic test_saturation();
    exp_t e;
    logic [CNTW+5:0] o, w;
    int c2;
    do_reset();
    for (int c = 0; c < 2*CMAX + 300; c++) begin
      @(negedge clk);
      drive(I(1, 2, 0, 1, 0, 2, 1, 1, 0));
      c2 = (c / 2 > CMAX) ? CMAX : c / 2;
      exp_q.push_back(E((c % 2 == 0) ? 1 : 0,
                        (c == 0) ? 0 : 2, 0,
                        c % 2, c % 2, c2));
      #1;
      e = exp_q.pop_front();
      o = {e.chk ? ForwardA : 2'b00, e.chk ? ForwardB : 2'b00,
           stall, bubble, stall_count};
      w = {e.chk ? e.fa : 2'b00, e.chk ? e.fb : 2'b00,
           e.st, e.bb, e.cnt};
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL sat[%0d] got fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d want fa=%0d fb=%0d st=%0b bb=%0b cnt=%0d",
                 c, ForwardA, ForwardB, stall, bubble, stall_count,
                 e.fa, e.fb, e.st, e.bb, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward_ex_mem_wb();
    test_load_use();
    test_priority();
    test_no_match();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
